tiny_cpu_sequencer: RTL and testbench
=====================================

Name: tiny_cpu_sequencer

Overview:
Program sequencer for the 8-bit TinyCPU datapath.
- Holds a small writable program store of 12-bit instruction words and issues them, one per Clk, onto the CPU's 12-bit instruction input.
- Captures the 8-bit CPU result for each issued instruction into a 2-entry valid/ready output buffer.
- When the consumer stalls, issues NOPs so the CPU never loses a result.

Parameters:
- DEPTH, 16: number of program words.
- AW, 4: address width; DEPTH == 2**AW.
- NOP_OP, 4'hF: opcode of the no-operation word. The decoder asserts no register enables for it.

Ports:
- Clk, input, 1: clock; all logic on rising edge.
- Clear, input, 1: synchronous active-high reset.
- LdEn, input, 1: program-store write strobe; honoured only in IDLE.
- LdAddr, input, AW: write address.
- LdData, input, 12: write word. [11:8] is the opcode, [7:0] is the data byte.
- Start, input, 1: one-cycle pulse; begins a run in IDLE; ignored elsewhere.
- LastAddr, input, AW: address of the final instruction; sampled on Start.
- Abort, input, 1: stop issuing; in-flight results are still delivered.
- CpuIn, output, 12: instruction word driven to the CPU.
- CpuResult, input, 8: CPU output-register value.
- ResData, output, 8: captured result.
- ResPc, output, AW: program address that produced ResData.
- ResValid, output, 1: ResData/ResPc valid.
- ResReady, input, 1: consumer accepts when ResValid && ResReady.
- Busy, output, 1: high in RUN or DRAIN.
- Done, output, 1: one-cycle pulse on return to IDLE.

Behaviour:
- Reset (Clear):
  - State IDLE, pc = 0, buffer empty, in-flight tracking cleared.
  - Outputs: CpuIn = {NOP_OP, 8'h00}, ResValid = 0, Busy = 0, Done = 0, ResData = 0, ResPc = 0.
  - Program store contents are not reset.
  - Clear mid-run discards all in-flight and buffered results.
- FSM states:
  - IDLE: CpuIn = NOP. LdEn writes mem[LdAddr]. Start latches LastAddr, sets pc = 0, goes to RUN. Start and LdEn in the same cycle: the write completes and the run starts; word 0 issued next cycle reflects the write.
  - RUN: each cycle, if credit is available, CpuIn = mem[pc] (registered output) and pc increments. Otherwise CpuIn = NOP and pc holds. Issuing the word at LastAddr moves to DRAIN. Abort moves to DRAIN without issuing that cycle.
  - DRAIN: CpuIn = NOP. Waits until no result is in flight and the buffer is empty, then goes to IDLE with Done = 1 for one cycle.
- Result timing:
  - A word on CpuIn in cycle k updates the CPU output register at the end of k.
  - The sequencer samples CpuResult at the end of cycle k+1, so ResValid rises in cycle k+2. Issue-to-ResValid latency is 2 cycles.
  - Every non-NOP issued word produces exactly one buffer entry, including words that do not change the output register (the entry then repeats the previous value).
- Credit rule: issue only when (buffer occupancy + in-flight count) < 2. In-flight is at most 2.
  - With ResReady held high, throughput is one word per cycle.
  - Simultaneous push and pop keeps occupancy constant.
- Buffer: 2-entry FIFO of {pc, data}, first-word on ResData/ResPc. ResValid = occupancy != 0.
- pc wraps from DEPTH-1 to 0 only if LastAddr < pc, which is impossible in normal use. A run always issues LastAddr+1 words (1..DEPTH).
- Abort in IDLE or DRAIN has no effect.

Optional Feature:
- Macro: TINY_SEQ_LOOP_EN.
- Enabled:
  - Adds input LoopCount [7:0], sampled on Start.
  - After LastAddr is issued, pc returns to 0 and the program reissues. Total passes = LoopCount+1.
  - Abort ends all passes.
  - Adds output Pass [7:0] (current pass, 0-based; reset 0).
- Disabled: single pass; no LoopCount/Pass ports.

Decomposition:
- Package tiny_cpu_pkg:
  - Word-field constants (OP_MSB=11, OP_LSB=8, DATA_MSB=7).
  - NOP word constant.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module seq_result_fifo: 2-deep FIFO, width AW+8, with push/pop/count.
- Program store and FSM stay in the top.

Test Plan:
1. Load words 0..3 = {4'h1, 8'h05}, {4'h1, 8'h03}, {4'h2, 8'h00}, {4'h3, 8'h00}; LastAddr = 3; Start; ResReady = 1 → CpuIn shows the 4 words on consecutive cycles; 4 ResValid beats with ResPc 0, 1, 2, 3, the first 2 cycles after the first issue; Done 1 cycle after the last accept.
2. Same program with ResReady = 0 for 6 cycles from the first ResValid → exactly 2 entries buffered, CpuIn = NOP while stalled; releasing ResReady delivers all 4 results in order with none lost or duplicated.
3. Abort in the second RUN cycle of an 8-word program → at most 2 words issued; their results are delivered, then Done; no further program words appear on CpuIn.
4. Clear asserted while 2 results are buffered → next cycle ResValid = 0, Busy = 0, CpuIn = NOP; a new Start runs cleanly from pc 0.
5. LdEn in RUN writing mem[2] ← 12'hABC → ignored; mem[2] unchanged on the next run. Start in RUN → ignored.
6. (TINY_SEQ_LOOP_EN) LoopCount = 2, LastAddr = 1 → 6 issues with pc sequence 0, 1, 0, 1, 0, 1; Pass = 0, 1, 2; one Done.

Source files
------------

// File: rtl/tiny_cpu_pkg.sv
// Shared constants for the TinyCPU program sequencer: instruction-word fields,
// the NOP word and FSM state encodings.
package tiny_cpu_pkg;

    localparam int unsigned WORD_W   = 12;
    localparam int unsigned OP_MSB   = 11;
    localparam int unsigned OP_LSB   = 8;
    localparam int unsigned DATA_MSB = 7;

    localparam logic [WORD_W-1:0] NOP_WORD = 12'hF00;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic [OP_MSB-OP_LSB:0] word_op(input logic [WORD_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [DATA_MSB:0] word_data(input logic [WORD_W-1:0] w);
        return w[DATA_MSB:0];
    endfunction

endpackage

// File: rtl/seq_result_fifo.sv
// Two-entry synchronous FIFO holding {pc, result} pairs for the sequencer.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module seq_result_fifo #(
    parameter int unsigned W = 12
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] slot_q [2];
    logic [W-1:0] slot_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        slot_d   = slot_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_data_i;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head_o  = slot_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tiny_cpu_sequencer.sv
// Program sequencer for the TinyCPU: issues stored words, captures results into a
// 2-entry buffer with credit-based flow control. Define TINY_SEQ_LOOP_EN for multi-pass runs.
module tiny_cpu_sequencer
    import tiny_cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter logic [3:0]  NOP_OP = 4'hF
) (
    input  logic          Clk,
    input  logic          Clear,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [11:0]   LdData,
    input  logic          Start,
    input  logic [AW-1:0] LastAddr,
    input  logic          Abort,
    output logic [11:0]   CpuIn,
    input  logic [7:0]    CpuResult,
    output logic [7:0]    ResData,
    output logic [AW-1:0] ResPc,
    output logic          ResValid,
    input  logic          ResReady,
`ifdef TINY_SEQ_LOOP_EN
    input  logic [7:0]    LoopCount,
    output logic [7:0]    Pass,
`endif
    output logic          Busy,
    output logic          Done
);

    localparam logic [11:0] NopWord = {NOP_OP, 8'h00};

    logic [11:0]   mem_q [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] last_q, last_d;
    logic          s2_valid_q, s2_valid_d;
    logic [AW-1:0] s2_pc_q, s2_pc_d;
    logic          done_q, done_d;
`ifdef TINY_SEQ_LOOP_EN
    logic [7:0]    loop_q, loop_d;
    logic [7:0]    pass_q, pass_d;
`endif

    logic [11:0]     mem_rd;
    logic            issue;
    logic            res_pop;
    logic [1:0]      fifo_count;
    logic [AW+7:0]   fifo_head;
    logic [2:0]      used;
    logic            credit_ok;

    assign mem_rd  = mem_q[pc_q];
    assign res_pop = ResValid && ResReady;

    // Slots committed after this cycle's pop: buffered plus the one result still in the CPU.
    assign used      = {1'b0, fifo_count} + {2'b00, s2_valid_q} - {2'b00, res_pop};
    assign credit_ok = (used < 3'd2);

    always_ff @(posedge Clk) begin
        if ((state_q == ST_IDLE) && LdEn) begin
            mem_q[LdAddr] <= LdData;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        done_d  = 1'b0;
        issue   = 1'b0;
`ifdef TINY_SEQ_LOOP_EN
        loop_d  = loop_q;
        pass_d  = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    last_d  = LastAddr;
                    pc_d    = '0;
                    state_d = ST_RUN;
`ifdef TINY_SEQ_LOOP_EN
                    loop_d  = LoopCount;
                    pass_d  = 8'd0;
`endif
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (pc_q == last_q) begin
`ifdef TINY_SEQ_LOOP_EN
                        if (pass_q != loop_q) begin
                            pc_d   = '0;
                            pass_d = pass_q + 8'd1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
`else
                        state_d = ST_DRAIN;
`endif
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once nothing remains after this cycle, so Done lands right after the last accept.
                if (used == 3'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s2_valid_d = issue && (word_op(mem_rd) != NOP_OP);
        s2_pc_d    = pc_q;
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            last_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_pc_q    <= '0;
            done_q     <= 1'b0;
`ifdef TINY_SEQ_LOOP_EN
            loop_q     <= 8'd0;
            pass_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            last_q     <= last_d;
            s2_valid_q <= s2_valid_d;
            s2_pc_q    <= s2_pc_d;
            done_q     <= done_d;
`ifdef TINY_SEQ_LOOP_EN
            loop_q     <= loop_d;
            pass_q     <= pass_d;
`endif
        end
    end

    // CPU register holds the previous cycle's result, so capture it one cycle after issue.
    seq_result_fifo #(
        .W(AW + 8)
    ) u_fifo (
        .clk_i      (Clk),
        .clear_i    (Clear),
        .push_i     (s2_valid_q),
        .push_data_i({s2_pc_q, CpuResult}),
        .pop_i      (res_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    assign CpuIn    = issue ? mem_rd : NopWord;
    assign ResValid = (fifo_count != 2'd0);
    assign ResPc    = fifo_head[AW+7:8];
    assign ResData  = fifo_head[7:0];
    assign Busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign Done     = done_q;
`ifdef TINY_SEQ_LOOP_EN
    assign Pass     = pass_q;
`endif

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Self-checking bench for tiny_cpu_sequencer: table-driven vectors plus directed
// multi-cycle sequences. Exercises the loop feature when TINY_SEQ_LOOP_EN is defined.
module tb_tiny_cpu_sequencer;
    import tiny_cpu_pkg::*;

    logic        Clk = 1'b0;
    logic        Clear, LdEn, Start, Abort, ResReady;
    logic [3:0]  LdAddr, LastAddr;
    logic [11:0] LdData;
    logic [11:0] CpuIn;
    logic [7:0]  CpuResult;
    logic [7:0]  ResData;
    logic [3:0]  ResPc;
    logic        ResValid, Busy, Done;
    logic [7:0]  loop_cnt = 8'd0;
    logic [7:0]  pass_w;
    logic [7:0]  cpu_reg = 8'h00;

    int checks = 0;
    int failures = 0;

    logic [3:0] bq_pc[$];
    logic [7:0] bq_data[$];
    logic [7:0] iq_pass[$];

    always #5 Clk = ~Clk;

    // CPU stand-in: output register loads {op,0} ^ data for every non-NOP word.
    always @(posedge Clk) begin
        if (CpuIn[11:8] != 4'hF) cpu_reg <= {CpuIn[11:8], 4'h0} ^ CpuIn[7:0];
    end
    assign CpuResult = cpu_reg;

    tiny_cpu_sequencer dut (
        .Clk      (Clk),
        .Clear    (Clear),
        .LdEn     (LdEn),
        .LdAddr   (LdAddr),
        .LdData   (LdData),
        .Start    (Start),
        .LastAddr (LastAddr),
        .Abort    (Abort),
        .CpuIn    (CpuIn),
        .CpuResult(CpuResult),
        .ResData  (ResData),
        .ResPc    (ResPc),
        .ResValid (ResValid),
        .ResReady (ResReady),
`ifdef TINY_SEQ_LOOP_EN
        .LoopCount(loop_cnt),
        .Pass     (pass_w),
`endif
        .Busy     (Busy),
        .Done     (Done)
    );
`ifndef TINY_SEQ_LOOP_EN
    assign pass_w = 8'd0;
`endif

    typedef struct {
        logic        start;
        logic        ready;
        logic [11:0] cpu;
        logic        valid;
        logic [7:0]  data;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic rdy, logic [11:0] cpu, logic vld,
                                logic [7:0] d, logic [3:0] p, logic bsy, logic dn);
        vec_t v;
        v.start = st; v.ready = rdy; v.cpu = cpu; v.valid = vld;
        v.data = d; v.pc = p; v.busy = bsy; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [11:0] d);
        LdEn = 1'b1; LdAddr = a; LdData = d;
        @(posedge Clk); #1;
        LdEn = 1'b0;
    endtask

    // Starts a run and records issues, accepted beats and Done until Done or the bound.
    task automatic run_collect(input logic [3:0] last, input int abort_at, input int inj_at,
                               output int n_iss, output int n_done);
        bq_pc.delete(); bq_data.delete(); iq_pass.delete();
        n_iss = 0; n_done = 0; LastAddr = last;
        for (int i = 0; i < 200; i++) begin
            Start = (i == 0) || (i == inj_at);
            Abort = (i == abort_at);
            LdEn  = (i == inj_at);
            if (i == inj_at) begin
                LdAddr = 4'd2; LdData = 12'hABC; LastAddr = 4'd0;
            end
            @(negedge Clk);
            if (CpuIn !== NOP_WORD) begin
                n_iss++;
                iq_pass.push_back(pass_w);
            end
            if (ResValid && ResReady) begin
                bq_pc.push_back(ResPc);
                bq_data.push_back(ResData);
            end
            if (Done) n_done++;
            @(posedge Clk); #1;
            if (n_done != 0) break;
        end
        Start = 1'b0; Abort = 1'b0; LdEn = 1'b0;
    endtask

    task automatic chk_beats(input string name, input logic [3:0] epc[$], input logic [7:0] ed[$]);
        chk({name, "_nbeats"}, 0, bq_pc.size(), epc.size());
        for (int k = 0; k < epc.size(); k++) begin
            if (k < bq_pc.size()) begin
                chk({name, "_pc"}, k, bq_pc[k], epc[k]);
                chk({name, "_data"}, k, bq_data[k], ed[k]);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n_iss, n_done;
        logic [3:0] epc[$];
        logic [7:0] ed[$];

        Clear = 1'b1; LdEn = 1'b0; Start = 1'b0; Abort = 1'b0; ResReady = 1'b1;
        LdAddr = '0; LdData = '0; LastAddr = '0;
        repeat (2) @(posedge Clk);
        #1 Clear = 1'b0;
        @(negedge Clk);
        chk("rst_cpu", 0, CpuIn, 12'hF00);
        chk("rst_valid", 0, ResValid, 1'b0);
        chk("rst_busy", 0, Busy, 1'b0);
        chk("rst_done", 0, Done, 1'b0);
        chk("rst_data", 0, ResData, 8'h00);
        chk("rst_pc", 0, ResPc, 4'h0);
        @(posedge Clk); #1;

        load(4'd0, 12'h105);
        load(4'd1, 12'h103);
        load(4'd2, 12'h200);
        load(4'd3, 12'h300);
        LastAddr = 4'd3;

        // Full-speed run, then the stalled run.
        vecs.push_back(mk(1, 1, 12'hF00, 0, 8'h00, 4'd0, 0, 0));
        vecs.push_back(mk(0, 1, 12'h105, 0, 8'h00, 4'd0, 1, 0));
        vecs.push_back(mk(0, 1, 12'h103, 0, 8'h00, 4'd0, 1, 0));
        vecs.push_back(mk(0, 1, 12'h200, 1, 8'h15, 4'd0, 1, 0));
        vecs.push_back(mk(0, 1, 12'h300, 1, 8'h13, 4'd1, 1, 0));
        vecs.push_back(mk(0, 1, 12'hF00, 1, 8'h20, 4'd2, 1, 0));
        vecs.push_back(mk(0, 1, 12'hF00, 1, 8'h30, 4'd3, 1, 0));
        vecs.push_back(mk(0, 1, 12'hF00, 0, 8'h00, 4'd0, 0, 1));
        vecs.push_back(mk(0, 1, 12'hF00, 0, 8'h00, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 12'hF00, 0, 8'h00, 4'd0, 0, 0));
        vecs.push_back(mk(0, 1, 12'h105, 0, 8'h00, 4'd0, 1, 0));
        vecs.push_back(mk(0, 1, 12'h103, 0, 8'h00, 4'd0, 1, 0));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(0, 0, 12'hF00, 1, 8'h15, 4'd0, 1, 0));
        vecs.push_back(mk(0, 1, 12'h200, 1, 8'h15, 4'd0, 1, 0));
        vecs.push_back(mk(0, 1, 12'h300, 1, 8'h13, 4'd1, 1, 0));
        vecs.push_back(mk(0, 1, 12'hF00, 1, 8'h20, 4'd2, 1, 0));
        vecs.push_back(mk(0, 1, 12'hF00, 1, 8'h30, 4'd3, 1, 0));
        vecs.push_back(mk(0, 1, 12'hF00, 0, 8'h00, 4'd0, 0, 1));

        for (int r = 0; r < vecs.size(); r++) begin
            Start = vecs[r].start;
            ResReady = vecs[r].ready;
            @(negedge Clk);
            chk("tbl_cpu", r, CpuIn, vecs[r].cpu);
            chk("tbl_valid", r, ResValid, vecs[r].valid);
            if (vecs[r].valid) begin
                chk("tbl_data", r, ResData, vecs[r].data);
                chk("tbl_pc", r, ResPc, vecs[r].pc);
            end
            chk("tbl_busy", r, Busy, vecs[r].busy);
            chk("tbl_done", r, Done, vecs[r].done);
            @(posedge Clk); #1;
        end
        Start = 1'b0; ResReady = 1'b1;

        epc = '{4'd0, 4'd1, 4'd2, 4'd3};
        ed  = '{8'h15, 8'h13, 8'h20, 8'h30};

        // Clear with two results buffered, then a clean rerun.
        ResReady = 1'b0; LastAddr = 4'd3; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) begin @(posedge Clk); #1; end
        Clear = 1'b1;
        @(negedge Clk);
        chk("clr_pre_valid", 0, ResValid, 1'b1);
        @(posedge Clk); #1;
        Clear = 1'b0;
        @(negedge Clk);
        chk("clr_valid", 0, ResValid, 1'b0);
        chk("clr_busy", 0, Busy, 1'b0);
        chk("clr_cpu", 0, CpuIn, 12'hF00);
        @(posedge Clk); #1;
        ResReady = 1'b1;
        run_collect(4'd3, -1, -1, n_iss, n_done);
        chk("clr_rerun_iss", 0, n_iss, 4);
        chk("clr_rerun_done", 0, n_done, 1);
        chk_beats("clr_rerun", epc, ed);

        // LdEn and Start during RUN are ignored.
        run_collect(4'd3, -1, 2, n_iss, n_done);
        chk("ign_iss", 0, n_iss, 4);
        chk("ign_done", 0, n_done, 1);
        chk_beats("ign_run", epc, ed);
        run_collect(4'd3, -1, -1, n_iss, n_done);
        chk_beats("ign_rerun", epc, ed);

        // Abort in the second RUN cycle of an 8-word program.
        for (int a = 0; a < 8; a++) load(4'(a), {4'h1, 8'h40 + 8'(a)});
        run_collect(4'd7, 2, -1, n_iss, n_done);
        chk("abort_iss", 0, n_iss, 1);
        chk("abort_done", 0, n_done, 1);
        epc = '{4'd0};
        ed  = '{8'h50};
        chk_beats("abort", epc, ed);
        @(negedge Clk);
        chk("abort_idle_cpu", 0, CpuIn, 12'hF00);
        chk("abort_idle_busy", 0, Busy, 1'b0);
        @(posedge Clk); #1;

`ifdef TINY_SEQ_LOOP_EN
        loop_cnt = 8'd2;
        run_collect(4'd1, -1, -1, n_iss, n_done);
        chk("loop_iss", 0, n_iss, 6);
        chk("loop_done", 0, n_done, 1);
        epc = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
        ed  = '{8'h50, 8'h51, 8'h50, 8'h51, 8'h50, 8'h51};
        chk_beats("loop", epc, ed);
        chk("loop_npass", 0, iq_pass.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < iq_pass.size()) chk("loop_pass", k, iq_pass[k], 8'(k / 2));
        end
        loop_cnt = 8'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
